// File: rtl/weight_mem_sequencer.sv
// Load/run sequencer for the banked weight memory: streams words into (layer, node) order,
// then sweeps layer addresses for the compute side. Define WEIGHT_SEQ_CHECKSUM_EN for the load checksum.
module weight_mem_sequencer #(
    parameter int LAYER_SIZE  = 4,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           load_start,
    input  logic                           in_valid,
    input  logic [BIT_SIZE-1:0]            in_data,
    output logic                           in_ready,
    output logic                           mem_we,
    output logic [$clog2(LAYER_DEPTH)-1:0] mem_layer,
    output logic [$clog2(LAYER_SIZE)-1:0]  mem_node,
    output logic [BIT_SIZE-1:0]            mem_data,
    input  logic                           run_start,
    output logic                           layer_valid,
    input  logic                           layer_ack,
    output logic                           loaded,
    output logic                           busy,
    output logic                           done,
    output logic [BIT_SIZE-1:0]            checksum
);

    localparam int LW = $clog2(LAYER_DEPTH);
    localparam int NW = $clog2(LAYER_SIZE);

    localparam logic [NW-1:0] NODE_LAST  = NW'(LAYER_SIZE - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(LAYER_DEPTH - 1);
    localparam logic [NW-1:0] NODE_ONE   = NW'(1);
    localparam logic [LW-1:0] LAYER_ONE  = LW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        LOADED = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t        state;
    logic [NW-1:0] node_cnt;
    logic [LW-1:0] layer_cnt;
    logic          xfer;

    assign in_ready = (state == LOAD);
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            node_cnt    <= '0;
            layer_cnt   <= '0;
            mem_we      <= 1'b0;
            mem_layer   <= '0;
            mem_node    <= '0;
            mem_data    <= '0;
            layer_valid <= 1'b0;
            loaded      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state     <= LOAD;
                        node_cnt  <= '0;
                        layer_cnt <= '0;
                        busy      <= 1'b1;
                        loaded    <= 1'b0;
                    end
                end

                LOAD: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_data  <= in_data;
                        mem_node  <= node_cnt;
                        mem_layer <= layer_cnt;
                        if (node_cnt == NODE_LAST) begin
                            node_cnt <= '0;
                            if (layer_cnt == LAYER_LAST) begin
                                layer_cnt <= '0;
                                state     <= LOADED;
                                loaded    <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                layer_cnt <= layer_cnt + LAYER_ONE;
                            end
                        end else begin
                            node_cnt <= node_cnt + NODE_ONE;
                        end
                    end
                end

                LOADED: begin
                    // The final write is presented during the first LOADED cycle; addresses park at 0 afterwards.
                    mem_node  <= '0;
                    mem_layer <= '0;
                    if (load_start) begin
                        state     <= LOAD;
                        node_cnt  <= '0;
                        layer_cnt <= '0;
                        loaded    <= 1'b0;
                        busy      <= 1'b1;
                    end else if (run_start) begin
                        state       <= RUN;
                        layer_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                RUN: begin
                    if (layer_ack) begin
                        if (mem_layer == LAYER_LAST) begin
                            state       <= LOADED;
                            layer_valid <= 1'b0;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            mem_layer   <= '0;
                        end else begin
                            mem_layer <= mem_layer + LAYER_ONE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_SEQ_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (load_start && (state == IDLE || state == LOADED)) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + in_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_mem_sequencer.sv
// Directed self-checking bench for weight_mem_sequencer (LAYER_SIZE=4, LAYER_DEPTH=3, BIT_SIZE=16).
module tb_weight_mem_sequencer;

    localparam int LS = 4;
    localparam int LD = 3;
    localparam int BS = 16;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic          in_valid;
    logic [BS-1:0] in_data;
    logic          in_ready;
    logic          mem_we;
    logic [1:0]    mem_layer;
    logic [1:0]    mem_node;
    logic [BS-1:0] mem_data;
    logic          run_start;
    logic          layer_valid;
    logic          layer_ack;
    logic          loaded;
    logic          busy;
    logic          done;
    logic [BS-1:0] checksum;

    int n_vec = 0;
    int n_err = 0;

    weight_mem_sequencer #(
        .LAYER_SIZE (LS),
        .LAYER_DEPTH(LD),
        .BIT_SIZE   (BS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_layer  (mem_layer),
        .mem_node   (mem_node),
        .mem_data   (mem_data),
        .run_start  (run_start),
        .layer_valid(layer_valid),
        .layer_ack  (layer_ack),
        .loaded     (loaded),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic load_words(input logic [BS-1:0] w);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        in_valid   = 1'b1;
        in_data    = w;
        for (int k = 0; k < LS * LD; k++) step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset;
        load_start = 1'b0; in_valid = 1'b0; in_data = '0; run_start = 1'b0; layer_ack = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        n_vec++;
        if ({in_ready, mem_we, layer_valid, loaded, busy, done} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 000000", {in_ready, mem_we, layer_valid, loaded, busy, done});
        end
        n_vec++;
        if ({mem_layer, mem_node, mem_data, checksum} !== '0) begin
            n_err++; $display("FAIL reset_buses got layer=%0d node=%0d data=%h sum=%h want all 0", mem_layer, mem_node, mem_data, checksum);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_back_to_back;
        logic [1:0] el, en;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || loaded !== 1'b0) begin
            n_err++; $display("FAIL load_enter got ready=%b busy=%b loaded=%b want 1 1 0", in_ready, busy, loaded);
        end
        for (int k = 0; k < LS * LD; k++) begin
            in_valid = 1'b1;
            in_data  = BS'(k + 1);
            step();
            el = 2'(k / LS);
            en = 2'(k % LS);
            n_vec++;
            if (mem_we !== 1'b1 || mem_data !== BS'(k + 1) || mem_layer !== el || mem_node !== en) begin
                n_err++; $display("FAIL b2b_write%0d got we=%b data=%h L=%0d N=%0d want 1 %h %0d %0d",
                                  k, mem_we, mem_data, mem_layer, mem_node, BS'(k + 1), el, en);
            end
            n_vec++;
            if (in_ready !== (k < LS * LD - 1)) begin
                n_err++; $display("FAIL b2b_ready%0d got %b want %b", k, in_ready, (k < LS * LD - 1));
            end
        end
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (mem_we !== 1'b0 || loaded !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || mem_node !== 2'd0) begin
            n_err++; $display("FAIL b2b_after got we=%b loaded=%b ready=%b busy=%b node=%0d want 0 1 0 0 0",
                              mem_we, loaded, in_ready, busy, mem_node);
        end
    endtask

    task automatic test_load_toggle;
        int w;
        logic [1:0] el, en;
        w = 0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        n_vec++;
        if (loaded !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL reload_enter got loaded=%b ready=%b want 0 1", loaded, in_ready);
        end
        for (int i = 0; i < 2 * LS * LD; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = BS'(16'h0100 + i);
            step();
            n_vec++;
            if (i % 2 == 0) begin
                el = 2'(w / LS);
                en = 2'(w % LS);
                if (mem_we !== 1'b1 || mem_data !== BS'(16'h0100 + i) || mem_layer !== el || mem_node !== en) begin
                    n_err++; $display("FAIL toggle_write%0d got we=%b data=%h L=%0d N=%0d want 1 %h %0d %0d",
                                      w, mem_we, mem_data, mem_layer, mem_node, BS'(16'h0100 + i), el, en);
                end
                w++;
            end else if (mem_we !== 1'b0) begin
                n_err++; $display("FAIL toggle_idle%0d got we=%b want 0", i, mem_we);
            end
        end
        in_valid = 1'b0;
        step();
        n_vec++;
        if (loaded !== 1'b1 || mem_we !== 1'b0 || w != LS * LD) begin
            n_err++; $display("FAIL toggle_end got loaded=%b we=%b writes=%0d want 1 0 12", loaded, mem_we, w);
        end
    endtask

    task automatic test_run_sweep;
        run_start = 1'b1;
        layer_ack = 1'b1;
        step();
        run_start = 1'b0;
        for (int l = 0; l < LD; l++) begin
            n_vec++;
            if (layer_valid !== 1'b1 || mem_layer !== 2'(l) || mem_we !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL sweep_layer%0d got valid=%b L=%0d we=%b busy=%b done=%b want 1 %0d 0 1 0",
                                  l, layer_valid, mem_layer, mem_we, busy, done, l);
            end
            step();
        end
        n_vec++;
        if (done !== 1'b1 || layer_valid !== 1'b0 || mem_layer !== 2'd0 || loaded !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL sweep_done got done=%b valid=%b L=%0d loaded=%b busy=%b want 1 0 0 1 0",
                              done, layer_valid, mem_layer, loaded, busy);
        end
        step();
        layer_ack = 1'b0;
        n_vec++;
        if (done !== 1'b0 || layer_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL sweep_post got done=%b valid=%b busy=%b want 0 0 0", done, layer_valid, busy);
        end
    endtask

    task automatic test_ignored;
        do_reset();
        run_start = 1'b1;
        layer_ack = 1'b1;
        step();
        step();
        run_start = 1'b0;
        layer_ack = 1'b0;
        n_vec++;
        if ({layer_valid, busy, loaded, in_ready, done} !== 5'b0) begin
            n_err++; $display("FAIL idle_run_ignored got %b want 00000", {layer_valid, busy, loaded, in_ready, done});
        end
        load_words(16'h0055);
        run_start = 1'b1;
        step();
        run_start  = 1'b0;
        load_start = 1'b1;
        step();
        step();
        load_start = 1'b0;
        n_vec++;
        if (layer_valid !== 1'b1 || in_ready !== 1'b0 || mem_layer !== 2'd0 || busy !== 1'b1 || loaded !== 1'b1 || mem_we !== 1'b0) begin
            n_err++; $display("FAIL run_load_ignored got valid=%b ready=%b L=%0d busy=%b loaded=%b we=%b want 1 0 0 1 1 0",
                              layer_valid, in_ready, mem_layer, busy, loaded, mem_we);
        end
        layer_ack = 1'b1;
        step();
        step();
        step();
        layer_ack = 1'b0;
        n_vec++;
        if (done !== 1'b1 || layer_valid !== 1'b0) begin
            n_err++; $display("FAIL run_finish got done=%b valid=%b want 1 0", done, layer_valid);
        end
    endtask

    task automatic test_reset_midload;
        do_reset();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0777;
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, mem_we, layer_valid, loaded, busy, done} !== 6'b0 || mem_node !== 2'd0 || mem_layer !== 2'd0 || mem_data !== '0) begin
            n_err++; $display("FAIL midload_async got flags=%b L=%0d N=%0d data=%h want all 0",
                              {in_ready, mem_we, layer_valid, loaded, busy, done}, mem_layer, mem_node, mem_data);
        end
        step();
        n_vec++;
        if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL midload_held got we=%b ready=%b want 0 0", mem_we, in_ready);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h00AA;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (mem_we !== 1'b1 || mem_layer !== 2'd0 || mem_node !== 2'd0 || mem_data !== 16'h00AA) begin
            n_err++; $display("FAIL midload_restart got we=%b L=%0d N=%0d data=%h want 1 0 0 00aa", mem_we, mem_layer, mem_node, mem_data);
        end
    endtask

    task automatic test_checksum;
        logic [BS-1:0] exp_sum;
`ifdef WEIGHT_SEQ_CHECKSUM_EN
        exp_sum = 16'h4000;
`else
        exp_sum = 16'h0000;
`endif
        do_reset();
        load_words(16'h3000);
        n_vec++;
        if (checksum !== exp_sum || loaded !== 1'b1) begin
            n_err++; $display("FAIL checksum got sum=%h loaded=%b want %h 1", checksum, loaded, exp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_load_back_to_back();
        test_load_toggle();
        test_run_sweep();
        test_ignored();
        test_reset_midload();
        test_checksum();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
